// File: rtl/corevx_defs_pkg.sv
// Shared definitions for the corevx pipeline.
// Includes icache command and response codes, fetch exception causes and the fetch state encoding.
package corevx_defs_pkg;

  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_LOAD      = 4'd2;
  localparam logic [3:0] CMD_STORE     = 4'd3;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] RSP_IDLE        = 4'd0;
  localparam logic [3:0] RSP_WAIT        = 4'd1;
  localparam logic [3:0] RSP_DONE        = 4'd2;
  localparam logic [3:0] RSP_ACCESSFAULT = 4'd3;
  localparam logic [3:0] RSP_PAGEFAULT   = 4'd4;
  localparam logic [3:0] RSP_MISSALIGNED = 4'd5;
  localparam logic [3:0] RSP_UNKNOWNTYPE = 4'd6;

  localparam logic [3:0] CAUSE_FETCH_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_FETCH_ACCESS     = 4'd1;
  localparam logic [3:0] CAUSE_FETCH_PAGE       = 4'd12;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    WAIT_RESET,
    FETCH,
    HOLD,
    FLUSH
  } fetch_state_t;

  // IDLE and WAIT both mean the cache has not finished the request yet.
  function automatic logic rsp_pending(input logic [3:0] rsp);
    return (rsp == RSP_IDLE) || (rsp == RSP_WAIT);
  endfunction

endpackage

// File: rtl/corevx_fetch.sv
// Instruction fetch stage: holds the PC, performs one icache access at a time and buffers
// the result in a single slot for execute. The slot also carries fetch faults and injected interrupts.
module corevx_fetch
  import corevx_defs_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_2000,
  parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_reset_done,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data,
  output logic [3:0]  c_cmd,
  output logic [31:0] c_address,
  output logic [31:0] f2e_instr,
  output logic [31:0] f2e_pc,
  output logic        f2e_exc_start,
  output logic [3:0]  f2e_cause,
  output logic        f2e_cause_interrupt,
  input  logic        e2f_ready,
  input  logic        e2f_exc_start,
  input  logic        e2f_exc_return,
  input  logic        e2f_flush,
  input  logic        e2f_branchtaken,
  input  logic [31:0] e2f_branchtarget,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic        irq_pending,
  input  logic [3:0]  irq_cause
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         busy, busy_n;
  logic [31:0]  slot_instr, slot_instr_n;
  logic [31:0]  slot_pc, slot_pc_n;
  logic         slot_exc, slot_exc_n;
  logic [3:0]   slot_cause, slot_cause_n;
  logic         slot_int, slot_int_n;
  logic         slot_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_RESET;
      pc         <= RESET_VECTOR;
      busy       <= 1'b0;
      slot_instr <= NOP_INSTR;
      slot_pc    <= RESET_VECTOR;
      slot_exc   <= 1'b0;
      slot_cause <= 4'd0;
      slot_int   <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      busy       <= busy_n;
      slot_instr <= slot_instr_n;
      slot_pc    <= slot_pc_n;
      slot_exc   <= slot_exc_n;
      slot_cause <= slot_cause_n;
      slot_int   <= slot_int_n;
    end
  end

  // Interrupts and misalignment are only considered before a cache access begins,
  // so an access that is already in progress is never abandoned.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    busy_n       = busy;
    slot_instr_n = slot_instr;
    slot_pc_n    = slot_pc;
    slot_exc_n   = slot_exc;
    slot_cause_n = slot_cause;
    slot_int_n   = slot_int;
    c_cmd        = CMD_NONE;
    c_address    = 32'd0;

    unique case (state)
      WAIT_RESET: begin
        if (c_reset_done) state_n = FETCH;
      end

      FETCH: begin
        if (!busy && irq_pending) begin
          slot_instr_n = NOP_INSTR;
          slot_pc_n    = pc;
          slot_exc_n   = 1'b1;
          slot_cause_n = irq_cause;
          slot_int_n   = 1'b1;
          state_n      = HOLD;
        end else if (!busy && (pc[1:0] != 2'b00)) begin
          slot_instr_n = NOP_INSTR;
          slot_pc_n    = pc;
          slot_exc_n   = 1'b1;
          slot_cause_n = CAUSE_FETCH_MISALIGNED;
          slot_int_n   = 1'b0;
          state_n      = HOLD;
        end else begin
          c_cmd     = CMD_EXECUTE;
          c_address = pc;
          if (rsp_pending(c_response)) begin
            busy_n = 1'b1;
          end else begin
            busy_n       = 1'b0;
            slot_pc_n    = pc;
            slot_int_n   = 1'b0;
            slot_instr_n = NOP_INSTR;
            slot_exc_n   = 1'b1;
            slot_cause_n = CAUSE_FETCH_ACCESS;
            if (c_response == RSP_DONE) begin
              slot_instr_n = c_load_data;
              slot_exc_n   = 1'b0;
              slot_cause_n = 4'd0;
            end else if (c_response == RSP_PAGEFAULT) begin
              slot_cause_n = CAUSE_FETCH_PAGE;
            end
            state_n = HOLD;
          end
        end
      end

      HOLD: begin
        if (e2f_ready) begin
          state_n = FETCH;
          if (e2f_exc_start)        pc_n = csr_mtvec;
          else if (e2f_exc_return)  pc_n = csr_mepc;
          else if (e2f_flush)       state_n = FLUSH;
          else if (e2f_branchtaken) pc_n = e2f_branchtarget;
          else                      pc_n = slot_pc + 32'd4;
        end
      end

      FLUSH: begin
        c_cmd = CMD_FLUSH_ALL;
        if (!rsp_pending(c_response)) begin
          pc_n    = slot_pc + 32'd4;
          state_n = FETCH;
        end
      end

      default: state_n = WAIT_RESET;
    endcase
  end

  assign slot_valid          = (state == HOLD);
  assign f2e_instr           = slot_valid ? slot_instr : NOP_INSTR;
  assign f2e_pc              = slot_valid ? slot_pc : pc;
  assign f2e_exc_start       = slot_valid & slot_exc;
  assign f2e_cause           = slot_valid ? slot_cause : 4'd0;
  assign f2e_cause_interrupt = slot_valid & slot_int;

endmodule

// File: tb/tb_corevx_fetch.sv
// Self-checking bench for corevx_fetch: a directed walk through the main fetch scenarios,
// followed by randomized traffic compared every cycle against a behavioural model of the fetch stage.
module tb_corevx_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_reset_done;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [31:0] f2e_instr;
  logic [31:0] f2e_pc;
  logic        f2e_exc_start;
  logic [3:0]  f2e_cause;
  logic        f2e_cause_interrupt;
  logic        e2f_ready;
  logic        e2f_exc_start;
  logic        e2f_exc_return;
  logic        e2f_flush;
  logic        e2f_branchtaken;
  logic [31:0] e2f_branchtarget;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        irq_pending;
  logic [3:0]  irq_cause;

  // Shadow inputs, copied onto the DUT at the falling edge
  logic        n_rst, n_reset_done, n_ready, n_exc_start, n_exc_ret, n_flush, n_br, n_irq;
  logic [3:0]  n_resp, n_irq_cause;
  logic [31:0] n_data, n_target, n_mtvec, n_mepc;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the PC, plus whether an instruction (or fault) is waiting for execute
  bit          m_booted, m_have_slot, m_flushing, m_open;
  logic [31:0] m_pc;
  logic [31:0] m_s_instr, m_s_pc;
  logic        m_s_exc, m_s_int;
  logic [3:0]  m_s_cause;

  corevx_fetch dut (
    .clk(clk), .rst(rst), .c_reset_done(c_reset_done), .c_response(c_response),
    .c_load_data(c_load_data), .c_cmd(c_cmd), .c_address(c_address),
    .f2e_instr(f2e_instr), .f2e_pc(f2e_pc), .f2e_exc_start(f2e_exc_start),
    .f2e_cause(f2e_cause), .f2e_cause_interrupt(f2e_cause_interrupt),
    .e2f_ready(e2f_ready), .e2f_exc_start(e2f_exc_start), .e2f_exc_return(e2f_exc_return),
    .e2f_flush(e2f_flush), .e2f_branchtaken(e2f_branchtaken), .e2f_branchtarget(e2f_branchtarget),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .irq_pending(irq_pending), .irq_cause(irq_cause)
  );

  always #5 clk = ~clk;

  task automatic checkLiteral(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_booted = 0; m_have_slot = 0; m_flushing = 0; m_open = 0;
    m_pc = 32'h0000_2000;
    m_s_pc = 32'h0000_2000;
  endtask

  task automatic checkOutput();
    logic [3:0]  e_cmd   = 4'd0;
    logic [31:0] e_addr  = 32'd0;
    logic [31:0] e_instr = 32'h0000_0013;
    logic [31:0] e_pc    = m_pc;
    logic        e_exc   = 1'b0;
    logic [3:0]  e_cause = 4'd0;
    logic        e_int   = 1'b0;
    if (m_booted) begin
      if (m_have_slot) begin
        e_instr = m_s_instr; e_pc = m_s_pc; e_exc = m_s_exc;
        e_cause = m_s_cause; e_int = m_s_int;
      end else if (m_flushing) begin
        e_cmd = 4'd4;
      end else if (m_open || (!irq_pending && (m_pc % 4 == 0))) begin
        e_cmd  = 4'd1;
        e_addr = m_pc;
      end
    end
    checkLiteral("model c_cmd", {28'd0, c_cmd}, {28'd0, e_cmd});
    checkLiteral("model c_address", c_address, e_addr);
    checkLiteral("model f2e_instr", f2e_instr, e_instr);
    checkLiteral("model f2e_pc", f2e_pc, e_pc);
    checkLiteral("model f2e_exc_start", {31'd0, f2e_exc_start}, {31'd0, e_exc});
    checkLiteral("model f2e_cause", {28'd0, f2e_cause}, {28'd0, e_cause});
    checkLiteral("model f2e_cause_interrupt", {31'd0, f2e_cause_interrupt}, {31'd0, e_int});
  endtask

  task automatic advanceModel();
    if (rst) begin
      modelReset();
    end else if (!m_booted) begin
      m_booted = c_reset_done;
    end else if (m_have_slot) begin
      if (e2f_ready) begin
        m_have_slot = 0;
        if (e2f_exc_start)        m_pc = csr_mtvec;
        else if (e2f_exc_return)  m_pc = csr_mepc;
        else if (e2f_flush)       m_flushing = 1;
        else if (e2f_branchtaken) m_pc = e2f_branchtarget;
        else                      m_pc = m_s_pc + 32'd4;
      end
    end else if (m_flushing) begin
      if (c_response > 4'd1) begin
        m_flushing = 0;
        m_pc = m_s_pc + 32'd4;
      end
    end else if (!m_open && irq_pending) begin
      m_s_instr = 32'h13; m_s_pc = m_pc; m_s_exc = 1; m_s_cause = irq_cause; m_s_int = 1;
      m_have_slot = 1;
    end else if (!m_open && (m_pc % 4 != 0)) begin
      m_s_instr = 32'h13; m_s_pc = m_pc; m_s_exc = 1; m_s_cause = 4'd0; m_s_int = 0;
      m_have_slot = 1;
    end else if (c_response <= 4'd1) begin
      m_open = 1;
    end else begin
      m_open = 0;
      m_s_pc = m_pc; m_s_int = 0;
      case (c_response)
        4'd2:    begin m_s_instr = c_load_data; m_s_exc = 0; m_s_cause = 4'd0;  end
        4'd4:    begin m_s_instr = 32'h13;      m_s_exc = 1; m_s_cause = 4'd12; end
        default: begin m_s_instr = 32'h13;      m_s_exc = 1; m_s_cause = 4'd1;  end
      endcase
      m_have_slot = 1;
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model
  task automatic applyStimulus();
    @(negedge clk);
    rst = n_rst; c_reset_done = n_reset_done; c_response = n_resp; c_load_data = n_data;
    e2f_ready = n_ready; e2f_exc_start = n_exc_start; e2f_exc_return = n_exc_ret;
    e2f_flush = n_flush; e2f_branchtaken = n_br; e2f_branchtarget = n_target;
    csr_mtvec = n_mtvec; csr_mepc = n_mepc; irq_pending = n_irq; irq_cause = n_irq_cause;
    #1;
    checkOutput();
    advanceModel();
  endtask

  task automatic setDefaults();
    n_ready = 0; n_exc_start = 0; n_exc_ret = 0; n_flush = 0; n_br = 0;
    n_resp = 4'd0; n_irq = 0; n_irq_cause = 4'd0;
  endtask

  initial begin
    rst = 1; c_reset_done = 0; c_response = 0; c_load_data = 0; e2f_ready = 0;
    e2f_exc_start = 0; e2f_exc_return = 0; e2f_flush = 0; e2f_branchtaken = 0;
    e2f_branchtarget = 0; csr_mtvec = 0; csr_mepc = 0; irq_pending = 0; irq_cause = 0;
    setDefaults();
    n_rst = 1; n_reset_done = 0; n_data = 0; n_target = 0; n_mtvec = 32'h100; n_mepc = 32'h0;
    modelReset();
    repeat (2) @(posedge clk);

    applyStimulus();
    checkLiteral("reset c_cmd", {28'd0, c_cmd}, 32'd0);
    checkLiteral("reset c_address", c_address, 32'd0);
    checkLiteral("reset f2e_pc", f2e_pc, 32'h2000);
    checkLiteral("reset f2e_instr", f2e_instr, 32'h13);
    checkLiteral("reset f2e_exc_start", {31'd0, f2e_exc_start}, 32'd0);

    n_rst = 0;
    repeat (3) applyStimulus();
    checkLiteral("wait_reset c_cmd", {28'd0, c_cmd}, 32'd0);
    n_reset_done = 1; applyStimulus();
    applyStimulus();
    checkLiteral("first fetch c_cmd", {28'd0, c_cmd}, 32'd1);
    checkLiteral("first fetch c_address", c_address, 32'h2000);
    n_resp = 4'd1; applyStimulus();
    n_resp = 4'd2; n_data = 32'h0050_0093; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("first slot f2e_instr", f2e_instr, 32'h0050_0093);
    checkLiteral("first slot f2e_pc", f2e_pc, 32'h2000);
    repeat (4) applyStimulus();
    checkLiteral("held slot f2e_instr", f2e_instr, 32'h0050_0093);
    n_ready = 1; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("sequential c_address", c_address, 32'h2004);
    n_resp = 4'd2; n_data = 32'h0010_0113; applyStimulus();

    setDefaults(); n_ready = 1; n_br = 1; n_target = 32'h2100; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("branch c_address", c_address, 32'h2100);
    n_resp = 4'd2; applyStimulus();
    setDefaults(); n_ready = 1; n_br = 1; n_target = 32'h2200; n_exc_start = 1; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("exception wins c_address", c_address, 32'h100);
    n_resp = 4'd2; applyStimulus();

    setDefaults(); n_ready = 1; n_br = 1; n_target = 32'h3000; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("pagefault c_address", c_address, 32'h3000);
    n_resp = 4'd4; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("pagefault exc", {31'd0, f2e_exc_start}, 32'd1);
    checkLiteral("pagefault cause", {28'd0, f2e_cause}, 32'd12);
    checkLiteral("pagefault instr", f2e_instr, 32'h13);
    n_ready = 1; n_br = 1; n_target = 32'h2102; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("misaligned no c_cmd", {28'd0, c_cmd}, 32'd0);
    applyStimulus();
    checkLiteral("misaligned exc", {31'd0, f2e_exc_start}, 32'd1);
    checkLiteral("misaligned cause", {28'd0, f2e_cause}, 32'd0);

    n_ready = 1; n_br = 1; n_target = 32'h2008; applyStimulus();
    setDefaults(); n_irq = 1; n_irq_cause = 4'd7; applyStimulus();
    checkLiteral("irq no c_cmd", {28'd0, c_cmd}, 32'd0);
    applyStimulus();
    checkLiteral("irq interrupt", {31'd0, f2e_cause_interrupt}, 32'd1);
    checkLiteral("irq cause", {28'd0, f2e_cause}, 32'd7);
    checkLiteral("irq f2e_pc", f2e_pc, 32'h2008);
    setDefaults(); n_ready = 1; applyStimulus();
    setDefaults(); applyStimulus(); n_resp = 4'd2; applyStimulus();
    setDefaults(); n_ready = 1; applyStimulus();
    setDefaults(); applyStimulus(); n_resp = 4'd2; applyStimulus();
    setDefaults(); applyStimulus();
    checkLiteral("flush slot f2e_pc", f2e_pc, 32'h2010);
    n_ready = 1; n_flush = 1; applyStimulus();
    setDefaults(); n_resp = 4'd1; applyStimulus();
    checkLiteral("flush c_cmd", {28'd0, c_cmd}, 32'd4);
    n_resp = 4'd2; applyStimulus();
    n_resp = 4'd1; applyStimulus();
    checkLiteral("after flush c_address", c_address, 32'h2014);
    n_rst = 1; applyStimulus();
    n_rst = 0; applyStimulus();
    checkLiteral("reset mid-access c_cmd", {28'd0, c_cmd}, 32'd0);
    checkLiteral("reset mid-access f2e_pc", f2e_pc, 32'h2000);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      n_rst = ($urandom_range(0, 199) == 0);
      n_reset_done = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 99);
      if (r < 40)      n_resp = 4'd1;
      else if (r < 50) n_resp = 4'd0;
      else if (r < 80) n_resp = 4'd2;
      else if (r < 85) n_resp = 4'd3;
      else if (r < 90) n_resp = 4'd4;
      else             n_resp = 4'($urandom_range(5, 15));
      n_data = $urandom();
      n_ready = ($urandom_range(0, 1) == 1);
      n_exc_start = ($urandom_range(0, 9) == 0);
      n_exc_ret = ($urandom_range(0, 9) == 0);
      n_flush = ($urandom_range(0, 9) == 0);
      n_br = ($urandom_range(0, 2) == 0);
      n_target = $urandom();
      if ($urandom_range(0, 3) != 0) n_target[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) n_target = 32'hFFFF_FFFC;
      n_mtvec = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      n_mepc = $urandom();
      if ($urandom_range(0, 3) != 0) n_mepc[1:0] = 2'b00;
      n_irq = ($urandom_range(0, 9) == 0);
      n_irq_cause = 4'($urandom_range(0, 15));
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
